// File: rtl/pcpu_gr_file_if.sv
// Register-file access bundle: ID read ports, ID issue, WB write.
// The ID/WB side is the master; the register file is the slave.
interface pcpu_gr_file_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_use;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     stall;
    logic                     wb_we;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;

    modport master (
        output rd_addr, rd_use, iss_valid, iss_addr,
        output wb_we, wb_addr, wb_data,
        input  rd_data, rd_busy, stall
    );

    modport slave (
        input  rd_addr, rd_use, iss_valid, iss_addr,
        input  wb_we, wb_addr, wb_data,
        output rd_data, rd_busy, stall
    );
endinterface

// File: rtl/pcpu_gr_file.sv
// General-register file with WB bypass and per-register pending-write
// counters that generate the ID-stage stall.
module pcpu_gr_file #(
    parameter int DATA_W       = 16,
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 3,
    parameter int NUM_RD       = 2,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2,
    parameter int ZERO_R0      = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    pcpu_gr_file_if.slave              bus,
    output logic [NUM_REGS*DATA_W-1:0] gr_flat,
    output logic                       err_underflow
);
    localparam logic [ADDR_W:0]  NREGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] MAXC  = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [DATA_W-1:0] gr  [NUM_REGS];
    logic [CNT_W-1:0]  cnt [NUM_REGS];

    logic              wb_ok;
    logic              iss_full;
    logic              issue_ok;
    logic              uflow;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    // A register that exists and is not the hard-wired zero.
    function automatic logic reg_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS) && !(ZERO_R0 != 0 && a == '0);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input logic [ADDR_W-1:0] a);
        return reg_ok(a) ? cnt[a] : '0;
    endfunction

    assign wb_ok = bus.wb_we && reg_ok(bus.wb_addr);

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [CNT_W-1:0]  c;
        logic              hit;

        assign a   = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign c   = cnt_of(a);
        assign hit = wb_ok && (bus.wb_addr == a);

        assign bus.rd_data[p*DATA_W +: DATA_W] =
            !reg_ok(a) ? '0 : (hit ? bus.wb_data : gr[a]);

        // The last outstanding write arriving now is covered by the bypass.
        assign bus.rd_busy[p] = (c != '0) && !(c == ONE && hit);
    end

    assign iss_full = bus.iss_valid
                    && (cnt_of(bus.iss_addr) == MAXC)
                    && !(wb_ok && bus.wb_addr == bus.iss_addr);

    assign bus.stall = (|(bus.rd_use & bus.rd_busy)) | iss_full;

    assign issue_ok = bus.iss_valid && enable && !bus.stall
                    && !flush && reg_ok(bus.iss_addr);

    assign uflow = wb_ok && !flush
                 && (cnt_of(bus.wb_addr) == '0)
                 && !(issue_ok && bus.iss_addr == bus.wb_addr);

    always_comb begin
        inc = '0;
        dec = '0;
        if (issue_ok)
            inc[bus.iss_addr] = 1'b1;
        if (wb_ok && !flush)
            dec[bus.wb_addr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                gr[r]  <= '0;
                cnt[r] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            if (wb_ok)
                gr[bus.wb_addr] <= bus.wb_data;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (flush)
                    cnt[r] <= '0;
                else if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + ONE;
                else if (dec[r] && !inc[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - ONE;
            end
            if (uflow)
                err_underflow <= 1'b1;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
        assign gr_flat[r*DATA_W +: DATA_W] = gr[r];
    end
endmodule

// File: tb/tb_pcpu_gr_file.sv
// Directed vector bench for pcpu_gr_file: default instance plus a
// ZERO_R0=1 instance for the hard-wired zero register.
module tb_pcpu_gr_file;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, fl;
    logic [127:0] flat;
    logic         err;

    logic         z_rst, z_en, z_fl;
    logic [127:0] z_flat;
    logic         z_err;

    pcpu_gr_file_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) bus ();
    pcpu_gr_file_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) zb ();

    pcpu_gr_file dut (
        .clock(clk), .reset(rst), .enable(en), .flush(fl),
        .bus(bus), .gr_flat(flat), .err_underflow(err)
    );

    pcpu_gr_file #(.ZERO_R0(1)) dut_z (
        .clock(clk), .reset(z_rst), .enable(z_en), .flush(z_fl),
        .bus(zb), .gr_flat(z_flat), .err_underflow(z_err)
    );

    typedef struct {
        logic        rst, en, fl;
        logic [2:0]  a0, a1;
        logic        u0, u1, iv;
        logic [2:0]  ia;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [15:0] d0, d1;
        logic [1:0]  bz;
        logic        st, er;
        logic [15:0] g3;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    vec_t tbl[25];

    initial begin
        // rst en fl a0 a1 u0 u1 iv ia we wa wd | d0 d1 bz st er g3
        tbl[0]  = '{1,0,0,3,0,0,0,0,0,0,0,16'h0,    16'h0,16'h0,2'b00,0,0,16'h0};
        tbl[1]  = '{0,1,0,3,0,0,0,0,0,1,3,16'hBEEF, 16'hBEEF,16'h0,2'b00,0,0,16'h0};
        tbl[2]  = '{0,1,0,3,3,0,0,0,0,0,0,16'h0,    16'hBEEF,16'hBEEF,2'b00,0,1,16'hBEEF};
        tbl[3]  = '{1,1,0,3,0,0,0,0,0,0,0,16'h0,    16'hBEEF,16'h0,2'b00,0,1,16'hBEEF};
        tbl[4]  = '{0,1,0,0,0,0,0,1,5,0,0,16'h0,    16'h0,16'h0,2'b00,0,0,16'h0};
        tbl[5]  = '{0,1,0,5,0,1,0,0,0,0,0,16'h0,    16'h0,16'h0,2'b01,1,0,16'h0};
        tbl[6]  = '{0,1,0,5,0,1,0,0,0,0,0,16'h0,    16'h0,16'h0,2'b01,1,0,16'h0};
        tbl[7]  = '{0,1,0,5,0,1,0,0,0,1,5,16'h1234, 16'h1234,16'h0,2'b00,0,0,16'h0};
        tbl[8]  = '{0,1,0,2,0,0,0,1,2,0,0,16'h0,    16'h0,16'h0,2'b00,0,0,16'h0};
        tbl[9]  = '{0,1,0,2,0,0,0,1,2,0,0,16'h0,    16'h0,16'h0,2'b01,0,0,16'h0};
        tbl[10] = '{0,1,0,2,0,0,0,1,2,0,0,16'h0,    16'h0,16'h0,2'b01,0,0,16'h0};
        tbl[11] = '{0,1,0,2,0,0,0,1,2,0,0,16'h0,    16'h0,16'h0,2'b01,1,0,16'h0};
        tbl[12] = '{0,1,0,2,0,0,0,1,2,1,2,16'h0022, 16'h0022,16'h0,2'b01,0,0,16'h0};
        tbl[13] = '{0,1,0,2,0,0,0,1,2,0,0,16'h0,    16'h0022,16'h0,2'b01,1,0,16'h0};
        tbl[14] = '{0,0,0,4,0,0,0,1,4,0,0,16'h0,    16'h0,16'h0,2'b00,0,0,16'h0};
        tbl[15] = '{0,1,0,4,0,1,0,0,0,0,0,16'h0,    16'h0,16'h0,2'b00,0,0,16'h0};
        tbl[16] = '{0,1,0,1,0,0,0,1,1,0,0,16'h0,    16'h0,16'h0,2'b00,0,0,16'h0};
        tbl[17] = '{0,1,0,1,0,0,0,1,1,0,0,16'h0,    16'h0,16'h0,2'b01,0,0,16'h0};
        tbl[18] = '{0,1,1,1,2,0,0,0,0,0,0,16'h0,    16'h0,16'h0022,2'b11,0,0,16'h0};
        tbl[19] = '{0,1,0,1,2,1,1,0,0,0,0,16'h0,    16'h0,16'h0022,2'b00,0,0,16'h0};
        tbl[20] = '{0,1,0,1,0,0,0,0,0,1,1,16'h00AA, 16'h00AA,16'h0,2'b00,0,0,16'h0};
        tbl[21] = '{0,1,0,1,0,0,0,0,0,0,0,16'h0,    16'h00AA,16'h0,2'b00,0,1,16'h0};
        tbl[22] = '{0,1,0,5,0,0,0,0,0,0,0,16'h0,    16'h1234,16'h0,2'b00,0,1,16'h0};
        tbl[23] = '{1,1,0,1,0,0,0,0,0,0,0,16'h0,    16'h00AA,16'h0,2'b00,0,1,16'h0};
        tbl[24] = '{0,1,0,1,0,0,0,0,0,0,0,16'h0,    16'h0,16'h0,2'b00,0,0,16'h0};

        rst = 1; en = 0; fl = 0;
        bus.rd_addr = '0; bus.rd_use = '0;
        bus.iss_valid = 0; bus.iss_addr = '0;
        bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;

        z_rst = 1; z_en = 0; z_fl = 0;
        zb.rd_addr = '0; zb.rd_use = '0;
        zb.iss_valid = 0; zb.iss_addr = '0;
        zb.wb_we = 0; zb.wb_addr = '0; zb.wb_data = '0;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_flat", 0, {31'd0, flat == '0}, 32'd1);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; en = tbl[i].en; fl = tbl[i].fl;
            bus.rd_addr   = {tbl[i].a1, tbl[i].a0};
            bus.rd_use    = {tbl[i].u1, tbl[i].u0};
            bus.iss_valid = tbl[i].iv;
            bus.iss_addr  = tbl[i].ia;
            bus.wb_we     = tbl[i].we;
            bus.wb_addr   = tbl[i].wa;
            bus.wb_data   = tbl[i].wd;
            #1;
            chk("rd_data0", i, {16'd0, bus.rd_data[15:0]}, {16'd0, tbl[i].d0});
            chk("rd_data1", i, {16'd0, bus.rd_data[31:16]}, {16'd0, tbl[i].d1});
            chk("rd_busy", i, {30'd0, bus.rd_busy}, {30'd0, tbl[i].bz});
            chk("stall", i, {31'd0, bus.stall}, {31'd0, tbl[i].st});
            chk("err_underflow", i, {31'd0, err}, {31'd0, tbl[i].er});
            chk("gr_flat3", i, {16'd0, flat[63:48]}, {16'd0, tbl[i].g3});
        end

        // Hard-wired zero register instance.
        @(negedge clk);
        z_rst = 0; z_en = 1;
        zb.wb_we = 1; zb.wb_addr = 3'd0; zb.wb_data = 16'hFFFF;
        zb.rd_addr = 6'd0;
        #1;
        chk("z_bypass_r0", 0, {16'd0, zb.rd_data[15:0]}, 32'd0);
        @(negedge clk);
        zb.wb_we = 0;
        #1;
        chk("z_read_r0", 1, {16'd0, zb.rd_data[15:0]}, 32'd0);
        chk("z_flat_r0", 1, {16'd0, z_flat[15:0]}, 32'd0);
        chk("z_err", 1, {31'd0, z_err}, 32'd0);

        zb.iss_valid = 1; zb.iss_addr = 3'd0; zb.rd_use = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("z_busy_r0", k, {30'd0, zb.rd_busy}, 32'd0);
            chk("z_stall_r0", k, {31'd0, zb.stall}, 32'd0);
        end
        zb.iss_valid = 0;
        zb.wb_we = 1; zb.wb_addr = 3'd0; zb.wb_data = 16'h5555;
        @(negedge clk);
        zb.wb_we = 0;
        #1;
        chk("z_err_after_wb", 0, {31'd0, z_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pcpu_gr_file.md
Name: pcpu_gr_file

Overview:
- Parametrised general-register file with scoreboard for the pipelined PCPU; next generation of the fixed 8x16 gr array.
- Adds configurable width, depth and read-port count, an optional hard-wired zero register, WB-to-ID write-through bypass, and per-register pending-write counters.
- The counters produce the ID-stage stall.
- Sits between ID (reads and issue), WB (writes) and the CPU control (enable/flush).

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of general registers
- ADDR_W, 3, register address width; NUM_REGS <= 2**ADDR_W
- NUM_RD, 2, number of read ports
- MAX_INFLIGHT, 3, maximum outstanding writes tracked per register
- CNT_W, 2, pending counter width; must hold MAX_INFLIGHT
- ZERO_R0, 0, when 1, gr0 reads as 0, ignores writes and is never pending

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  CPU run state; 0 blocks issue
- flush  in  1  pipeline squash; clears all pending counters
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_use  in  NUM_RD  port i operand is actually needed by the ID instruction
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  port i register has an unresolved pending write
- iss_valid  in  1  ID instruction writes a destination register
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- stall  out  1  hold IF/ID this cycle
- wb_we  in  1  WB write strobe
- wb_addr  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB data
- gr_flat  out  NUM_REGS*DATA_W  all registers, registered values, for debug
- err_underflow  out  1  sticky: a writeback arrived for a register with zero pending writes

Behaviour:
- Reset (synchronous, active-high; takes priority over all other inputs):
  - all registers and counters become 0; err_underflow becomes 0.
  - rd_data reflects zeros and wb bypass; stall is 0 unless an input combination asserts it.
- Write:
  - wb_we commits wb_data into gr[wb_addr] at the clock edge, independent of enable and stall.
  - An out-of-range address (>= NUM_REGS) is ignored.
  - ZERO_R0=1 with wb_addr=0 is ignored.
- Read (0-cycle, combinational):
  - rd_data[i] = wb_data when wb_we and wb_addr == rd_addr[i] (bypass); otherwise gr[rd_addr[i]].
  - Out-of-range or zero-register reads return 0.
- Busy:
  - rd_busy[i] = cnt[rd_addr[i]] != 0, except 0 when cnt == 1 and a same-cycle wb to that register is present (the bypass resolves it).
- Stall:
  - stall = OR over i of (rd_use[i] & rd_busy[i]), OR (iss_valid & cnt[iss_addr] == MAX_INFLIGHT & no same-cycle wb to iss_addr).
- Issue:
  - Issue is accepted when iss_valid & enable & !stall & !flush.
  - On acceptance, cnt[iss_addr] increments at the edge.
- Writeback counting:
  - wb_we decrements cnt[wb_addr].
  - Issue and wb to the same register in the same cycle leave the count unchanged.
  - wb with cnt == 0: count stays 0, data is still written, err_underflow sets and holds until reset.
- Flush:
  - All counters become 0 at the edge.
  - A same-cycle issue is dropped; a same-cycle wb still writes data but does not touch counters and does not flag underflow.
- enable = 0: no issue is counted; reads, writes and busy keep operating, so WB drains.
- Counters never wrap; the MAX_INFLIGHT stall guarantees this.

Test Plan:
- Reset then read gr3 on port 0 -> rd_data = 0x0000, rd_busy = 0, stall = 0, gr_flat all zeros.
- Write gr3 = 0xBEEF while reading gr3 in the same cycle -> rd_data = 0xBEEF (bypass); next cycle gr_flat[3] = 0xBEEF.
- Issue gr5, then ID reads gr5 with rd_use = 1 -> stall = 1 every cycle until wb gr5 = 0x1234. In the wb cycle: rd_busy = 0, stall = 0, rd_data = 0x1234.
- Three issues to gr2 with no wb, then a fourth iss_valid -> stall = 1 and the count stays 3. After one wb the fourth issue is accepted; count = 3.
- Two issues to gr1, then flush -> counts 0, rd_busy = 0. A subsequent wb gr1 = 0x00AA writes the data and sets err_underflow = 1, which stays 1 until reset.
- ZERO_R0 = 1: wb gr0 = 0xFFFF, then read gr0 -> 0x0000. Issue to gr0 -> never busy, never stalls.
